ascp_ctrl: RTL and testbench

ASCP_CTRL -- requirements
Module: ascp_ctrl

---
 rtl/ascp_ctrl.sv | 125 ++++++++++++
 tb/tb_ascp_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascp_ctrl.sv
// ascp_ctrl: handshake wrapper around an ascon_p permutation core.
// Takes a 5*BW state from upstream, launches one permutation, and parks the
// result in an output register until downstream takes it.
// Optional build macro ASCP_CTRL_TIMEOUT_EN adds a BUSY watchdog that aborts
// a permutation after TIMEOUT cycles and raises a sticky err flag.
module ascp_ctrl #(
   parameter int BW      = 64,
   parameter int TIMEOUT = 31
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [5*BW-1:0] in_state,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [5*BW-1:0] out_state,
   output logic            p_load,
   output logic [5*BW-1:0] p_s_in,
   input  logic [5*BW-1:0] p_s_out,
   input  logic            p_done,
   output logic [15:0]     perm_cnt,
   output logic            err
);

   typedef enum logic [1:0] {IDLE, LOAD, BUSY} state_t;

   state_t      state;
   state_t      state_nxt;
   logic        run_en;
   logic        in_xfer;
   logic        out_xfer;
   logic        done;
   logic        tmo;
   logic [15:0] cnt_q;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;
   // p_done only counts while a permutation is actually in flight
   assign done     = (state == BUSY) & p_done;
   assign perm_cnt = cnt_q;

`ifdef ASCP_CTRL_TIMEOUT_EN
   localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   logic [TW-1:0] tcnt;

   // Watchdog: cleared while p_load is high, counts every BUSY cycle
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)              tcnt <= '0;
      else if (state == LOAD) tcnt <= '0;
      else if (state == BUSY) tcnt <= tcnt + 1'b1;
   end

   // The TIMEOUT-th BUSY cycle without p_done aborts the permutation
   assign tmo = (state == BUSY) & ~p_done & (tcnt == TW'(TIMEOUT - 1));

   // Sticky abort flag, only reset clears it
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)    err <= 1'b0;
      else if (tmo) err <= 1'b1;
   end
`else
   // TIMEOUT only matters when the watchdog is built in
   localparam int UNUSED_TIMEOUT = TIMEOUT;

   assign tmo = 1'b0;
   assign err = 1'b0;
`endif

   // Hold off in_ready until the first clock edge after reset release
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) run_en <= 1'b0;
      else       run_en <= 1'b1;
   end

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_xfer)    state_nxt = LOAD;
         LOAD:                    state_nxt = BUSY;
         BUSY:    if (done | tmo) state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase
   end

   // Outputs: accept only in IDLE and only if the result slot is free or draining
   always_comb begin
      in_ready = run_en & (state == IDLE) & (~out_valid | out_ready);
      p_load   = (state == LOAD);
   end

   // Capture the incoming state; it stays put through LOAD and BUSY
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)        p_s_in <= '0;
      else if (in_xfer) p_s_in <= in_state;
   end

   // Result register: a new result wins over a same-edge drain
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         out_state <= '0;
      end else if (done) begin
         out_valid <= 1'b1;
         out_state <= p_s_out;
      end else if (out_xfer) begin
         out_valid <= 1'b0;
      end
   end

   // Completed-permutation counter, wraps naturally at 16 bits
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)     cnt_q <= '0;
      else if (done) cnt_q <= cnt_q + 16'd1;
   end

endmodule

// File: tb/tb_ascp_ctrl.sv
// tb_ascp_ctrl: directed bench for ascp_ctrl with a behavioural ascon_p stand-in.
module tb_ascp_ctrl;
   localparam int BW = 64;
   localparam int SW = 5 * BW;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [SW-1:0] in_state = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [SW-1:0] out_state;
   logic          p_load;
   logic [SW-1:0] p_s_in;
   logic [SW-1:0] p_s_out = '0;
   logic          p_done;
   logic [15:0]   perm_cnt;
   logic          err;

   int checks = 0;
   int errors = 0;

   ascp_ctrl #(.BW(BW), .TIMEOUT(31)) dut (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
      .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
      .p_load(p_load), .p_s_in(p_s_in), .p_s_out(p_s_out), .p_done(p_done),
      .perm_cnt(perm_cnt), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [SW-1:0] act, input logic [SW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, act, exp);
      end
   endtask

   // Stand-in permutation: rotate left by one bit, then xor a constant
   function automatic logic [SW-1:0] perm_model(input logic [SW-1:0] s);
      return {s[SW-2:0], s[SW-1]} ^ {5{64'hA5A5_5A5A_C3C3_3C3C}};
   endfunction

   // ascon_p responder and protocol monitor, all on the falling edge
   int   pdly = 12;
   int   rcnt = 0;
   int   lcnt = 0;
   int   rdy_viol = 0;
   int   dbl_load = 0;
   logic resp_done = 1'b0;
   logic man_done = 1'b0;
   logic busy_win = 1'b0;
   logic prev_load = 1'b0;
   logic last_done = 1'b0;

   assign p_done = resp_done | man_done;

   always @(negedge clk) begin
      if (last_done) busy_win = 1'b0;
      resp_done = 1'b0;
      if (!rstn) begin
         rcnt = 0;
         busy_win = 1'b0;
         prev_load = 1'b0;
      end else begin
         if (p_load) begin
            lcnt++;
            if (prev_load) dbl_load++;
            rcnt = pdly;
            busy_win = 1'b1;
         end else if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) begin
               resp_done = 1'b1;
               p_s_out = perm_model(p_s_in);
            end
         end
         if (busy_win && in_ready && pdly > 0) rdy_viol++;
         prev_load = p_load;
      end
      last_done = resp_done | man_done;
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [SW-1:0] v);
      int k;
      in_valid = 1'b1;
      in_state = v;
      k = 0;
      while (!in_ready && k < 300) begin
         cyc(1);
         k++;
      end
      chk("in_ready_wait", in_ready, 1);
      cyc(1);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 300) begin
         cyc(1);
         n++;
      end
      chk("out_valid_wait", out_valid, 1);
   endtask

   logic [SW-1:0] v0, v1, va, vb, vc;
   logic [SW-1:0] vec [10];
   int            n;

   initial begin
      v0 = {64'h00400C0000000100, 256'h0};
      v1 = {5{64'h0123_4567_89AB_CDEF}};
      va = {5{64'hDEAD_BEEF_0000_FFFF}};
      vb = {64'h1, 64'h2, 64'h3, 64'h4, 64'h5};
      vc = {5{64'hFFFF_0000_1234_5678}};
      for (int i = 0; i < 10; i++)
         vec[i] = {5{64'h9E37_79B9_7F4A_7C15 * 64'(i + 1)}} ^ {64'(i), 256'h0};

      // Reset state, with in_valid already offered
      in_valid = 1'b1;
      in_state = v0;
      cyc(3);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_p_load", p_load, 0);
      chk("rst_p_s_in", p_s_in, 0);
      chk("rst_out_state", out_state, 0);
      chk("rst_perm_cnt", perm_cnt, 0);
      chk("rst_err", err, 0);
      rstn = 1'b1;
      #1;
      chk("rel_in_ready_low", in_ready, 0);
      cyc(1);
      chk("rel_in_ready_high", in_ready, 1);

      // First permutation, done 12 cycles after p_load
      pdly = 12;
      send(v0);
      chk("first_p_load", p_load, 1);
      chk("first_p_s_in", p_s_in, v0);
      wait_out(n);
      chk("first_latency", n, 13);
      chk("first_out_state", out_state, perm_model(v0));
      chk("first_perm_cnt", perm_cnt, 1);
      chk("first_load_cnt", lcnt, 1);

      // Downstream stalled: no new start, result held
      in_valid = 1'b1;
      in_state = v1;
      cyc(20);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_load_cnt", lcnt, 1);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_state", out_state, perm_model(v0));
      out_ready = 1'b1;
      #1;
      chk("drain_in_ready", in_ready, 1);
      cyc(1);
      in_valid = 1'b0;
      chk("both_xfer_out_valid", out_valid, 0);
      chk("both_xfer_p_load", p_load, 1);
      chk("both_xfer_p_s_in", p_s_in, v1);
      wait_out(n);
      chk("second_out_state", out_state, perm_model(v1));
      chk("second_perm_cnt", perm_cnt, 2);

      // Ten back-to-back permutations with varying core latency
      for (int i = 0; i < 10; i++) begin
         pdly = 1 + (i % 5);
         send(vec[i]);
         wait_out(n);
         chk($sformatf("b2b_out_%0d", i), out_state, perm_model(vec[i]));
      end
      chk("b2b_perm_cnt", perm_cnt, 12);
      chk("b2b_load_cnt", lcnt, 12);
      cyc(1);
      chk("b2b_out_valid_clear", out_valid, 0);

      // Reset three cycles into BUSY, then a stray p_done in IDLE
      pdly = 20;
      send(va);
      cyc(3);
      rstn = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_perm_cnt", perm_cnt, 0);
      chk("midrst_p_s_in", p_s_in, 0);
      chk("midrst_in_ready", in_ready, 0);
      cyc(2);
      rstn = 1'b1;
      man_done = 1'b1;
      cyc(1);
      man_done = 1'b0;
      cyc(2);
      chk("stray_done_out_valid", out_valid, 0);
      chk("stray_done_perm_cnt", perm_cnt, 0);
      chk("stray_done_p_load", p_load, 0);
      pdly = 3;
      send(vb);
      wait_out(n);
      chk("post_rst_out_state", out_state, perm_model(vb));
      chk("post_rst_perm_cnt", perm_cnt, 1);
      cyc(1);

`ifdef ASCP_CTRL_TIMEOUT_EN
      // Core never answers: watchdog aborts after 31 BUSY cycles
      pdly = 0;
      send(vc);
      chk("tmo_p_load", p_load, 1);
      n = 0;
      while (!err && n < 100) begin
         cyc(1);
         n++;
      end
      chk("tmo_cycles", n, 32);
      chk("tmo_err", err, 1);
      chk("tmo_in_ready", in_ready, 1);
      chk("tmo_out_valid", out_valid, 0);
      chk("tmo_perm_cnt", perm_cnt, 1);
      cyc(5);
      chk("tmo_err_sticky", err, 1);
      chk("tmo_no_output", out_valid, 0);
      rstn = 1'b0;
      #1;
      chk("tmo_err_rst", err, 0);
      cyc(1);
      rstn = 1'b1;
      cyc(1);
`else
      // Core slow to answer: BUSY waits as long as it takes
      pdly = 0;
      send(vc);
      cyc(60);
      chk("slow_in_ready", in_ready, 0);
      chk("slow_out_valid", out_valid, 0);
      chk("slow_err", err, 0);
      man_done = 1'b1;
      cyc(1);
      man_done = 1'b0;
      chk("slow_done_out_valid", out_valid, 1);
      chk("slow_done_perm_cnt", perm_cnt, 2);
      cyc(1);
`endif

      // Counter wrap: preset to 0xFFFF, one more completion gives 0
      force dut.cnt_q = 16'hFFFF;
      #1;
      release dut.cnt_q;
      #1;
      chk("wrap_preset", perm_cnt, 16'hFFFF);
      pdly = 2;
      send(v1);
      wait_out(n);
      chk("wrap_out_state", out_state, perm_model(v1));
      chk("wrap_perm_cnt", perm_cnt, 0);
      cyc(1);

      chk("busy_in_ready_viol", rdy_viol, 0);
      chk("double_p_load", dbl_load, 0);
`ifndef ASCP_CTRL_TIMEOUT_EN
      chk("err_tied_low", err, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
